// File: rtl/pipe_buf_if.sv
// Handshake bundle between an upstream stage, pipe_buf and a downstream stage.
// Valid/ready: a payload moves on a cycle where valid=1 and allowin=1 are seen together at the rising edge.
interface pipe_buf_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_allowin;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_allowin;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_data, out_allowin,
    input  in_allowin, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_allowin,
    output in_allowin, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_buf.sv
// Circular-buffer pipeline stage with flush; DEPTH=1 behaves as a plain stage register.
// Optional macro PIPE_BUF_BYPASS_EN lets an empty buffer forward in_data to out_data in the same cycle.
module pipe_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  pipe_buf_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_empty;
  logic              w_full;
  logic              w_in_allowin;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_data;
  logic              w_push;
  logic              w_pop;
  logic              w_store;
  logic              w_pop_mem;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

  // A full buffer still accepts when the head leaves in the same cycle.
  assign w_in_allowin = !w_full || bus.out_allowin;

`ifdef PIPE_BUF_BYPASS_EN
  logic w_bypass;
  assign w_bypass    = w_empty && bus.in_valid && !flush;
  assign w_out_valid = (!w_empty && !flush) || w_bypass;
  assign w_out_data  = w_bypass    ? bus.in_data :
                       w_out_valid ? r_mem[r_rd_ptr] : '0;
  assign w_push      = bus.in_valid && w_in_allowin && !flush;
  assign w_pop       = w_out_valid && bus.out_allowin;
  // A bypassed payload taken downstream is neither stored nor popped from storage.
  assign w_store     = w_push && !(w_bypass && bus.out_allowin);
  assign w_pop_mem   = w_pop && !w_empty;
`else
  assign w_out_valid = !w_empty && !flush;
  assign w_out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
  assign w_push      = bus.in_valid && w_in_allowin && !flush;
  assign w_pop       = w_out_valid && bus.out_allowin;
  assign w_store     = w_push;
  assign w_pop_mem   = w_pop;
`endif

  assign bus.in_allowin = w_in_allowin;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = w_out_data;
  assign bus.count      = r_count;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_store)   r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_mem) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_store, w_pop_mem})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; only the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr_ptr] <= bus.in_data;
  end
endmodule

// File: tb/tb_pipe_buf.sv
// Directed bench for pipe_buf: DEPTH=2 instance for handshake/flush/reset cases,
// DEPTH=3 instance for an ordered stream with random downstream stalls.
module tb_pipe_buf;
  logic clk;
  logic reset;
  logic flush2;
  logic flush3;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_q[$];

  pipe_buf_if #(.DATA_W(32), .DEPTH(2)) bus2 ();
  pipe_buf_if #(.DATA_W(32), .DEPTH(3)) bus3 ();

  pipe_buf #(.DATA_W(32), .DEPTH(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .flush (flush2),
    .bus   (bus2)
  );

  pipe_buf #(.DATA_W(32), .DEPTH(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .flush (flush3),
    .bus   (bus3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic push2(input logic [31:0] d);
    bus2.in_valid = 1'b1;
    bus2.in_data  = d;
    step();
    bus2.in_valid = 1'b0;
  endtask

  initial begin
    int pushed;
    int popped;
    int cyc;
    logic [31:0] head;

    reset = 1'b1;
    flush2 = 1'b0;
    flush3 = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_allowin = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.out_allowin = 1'b0;
    step();
    step();
    reset = 1'b0;
    settle();

    chk("rst_count",      32'(bus2.count), 32'd0);
    chk("rst_out_valid",  32'(bus2.out_valid), 32'd0);
    chk("rst_out_data",   bus2.out_data, 32'h0);
    chk("rst_in_allowin", 32'(bus2.in_allowin), 32'd1);

    // Fill to full with downstream stalled, then drain in order.
    bus2.in_valid = 1'b1;
    bus2.in_data  = 32'h1111_1111;
    settle();
    chk("lat_no_same_cycle", 32'(bus2.out_valid), 32'd0);
    step();
    bus2.in_data = 32'h2222_2222;
    settle();
    chk("one_count", 32'(bus2.count), 32'd1);
    chk("one_head",  bus2.out_data, 32'h1111_1111);
    step();
    bus2.in_valid = 1'b0;
    settle();
    chk("full_count",     32'(bus2.count), 32'd2);
    chk("full_allowin",   32'(bus2.in_allowin), 32'd0);
    bus2.out_allowin = 1'b1;
    settle();
    chk("full_pop_allowin", 32'(bus2.in_allowin), 32'd1);
    chk("drain_first",      bus2.out_data, 32'h1111_1111);
    step();
    settle();
    chk("drain_second",     bus2.out_data, 32'h2222_2222);
    chk("drain_cnt1",       32'(bus2.count), 32'd1);
    step();
    settle();
    chk("drain_empty_cnt",  32'(bus2.count), 32'd0);
    chk("drain_empty_vld",  32'(bus2.out_valid), 32'd0);
    chk("drain_empty_data", bus2.out_data, 32'h0);

    // Full buffer with simultaneous push and pop.
    bus2.out_allowin = 1'b0;
    push2(32'h1111_1111);
    push2(32'h2222_2222);
    bus2.in_valid    = 1'b1;
    bus2.in_data     = 32'h3333_3333;
    bus2.out_allowin = 1'b1;
    settle();
    chk("pp_allowin", 32'(bus2.in_allowin), 32'd1);
    chk("pp_head",    bus2.out_data, 32'h1111_1111);
    step();
    bus2.in_valid = 1'b0;
    settle();
    chk("pp_count",   32'(bus2.count), 32'd2);
    chk("pp_next",    bus2.out_data, 32'h2222_2222);
    step();
    settle();
    chk("pp_third",   bus2.out_data, 32'h3333_3333);
    step();
    settle();
    chk("pp_empty",   32'(bus2.count), 32'd0);

    // Flush while full, with a push presented and downstream ready.
    bus2.out_allowin = 1'b0;
    push2(32'hAAAA_0001);
    push2(32'hAAAA_0002);
    bus2.in_valid    = 1'b1;
    bus2.in_data     = 32'hBAD0_BAD0;
    bus2.out_allowin = 1'b1;
    flush2           = 1'b1;
    settle();
    chk("fl_out_valid", 32'(bus2.out_valid), 32'd0);
    chk("fl_out_data",  bus2.out_data, 32'h0);
    step();
    flush2 = 1'b0;
    bus2.in_valid = 1'b0;
    settle();
    chk("fl_count",     32'(bus2.count), 32'd0);
    chk("fl_valid_aft", 32'(bus2.out_valid), 32'd0);
    bus2.out_allowin = 1'b0;
    push2(32'h4444_4444);
    settle();
    chk("fl_no_ghost",  bus2.out_data, 32'h4444_4444);
    chk("fl_cnt_one",   32'(bus2.count), 32'd1);
    bus2.out_allowin = 1'b1;
    step();
    bus2.out_allowin = 1'b0;

    // Reset dominates flush, push and pop on a full buffer.
    push2(32'h5555_5555);
    push2(32'h6666_6666);
    reset            = 1'b1;
    flush2           = 1'b1;
    bus2.in_valid    = 1'b1;
    bus2.in_data     = 32'h7777_7777;
    bus2.out_allowin = 1'b1;
    step();
    reset            = 1'b0;
    flush2           = 1'b0;
    bus2.in_valid    = 1'b0;
    bus2.out_allowin = 1'b0;
    settle();
    chk("rd_count",   32'(bus2.count), 32'd0);
    chk("rd_valid",   32'(bus2.out_valid), 32'd0);
    chk("rd_data",    bus2.out_data, 32'h0);
    chk("rd_allowin", 32'(bus2.in_allowin), 32'd1);

    // Empty buffer, push with downstream ready.
    bus2.in_valid    = 1'b1;
    bus2.in_data     = 32'hDEAD_BEEF;
    bus2.out_allowin = 1'b1;
    settle();
`ifdef PIPE_BUF_BYPASS_EN
    chk("byp_valid", 32'(bus2.out_valid), 32'd1);
    chk("byp_data",  bus2.out_data, 32'hDEAD_BEEF);
    step();
    bus2.in_valid = 1'b0;
    settle();
    chk("byp_count", 32'(bus2.count), 32'd0);
    chk("byp_after", 32'(bus2.out_valid), 32'd0);
`else
    chk("nobyp_valid", 32'(bus2.out_valid), 32'd0);
    chk("nobyp_data",  bus2.out_data, 32'h0);
    step();
    bus2.in_valid = 1'b0;
    settle();
    chk("nobyp_count", 32'(bus2.count), 32'd1);
    chk("nobyp_head",  bus2.out_data, 32'hDEAD_BEEF);
    step();
    settle();
    chk("nobyp_drain", 32'(bus2.count), 32'd0);
`endif
    bus2.out_allowin = 1'b0;

    // DEPTH=3 ordered stream with random stalls; scoreboard on exp_q.
    pushed = 0;
    popped = 0;
    cyc    = 0;
    while ((pushed < 10 || exp_q.size() != 0) && cyc < 300) begin
      bus3.in_valid    = (pushed < 10);
      bus3.in_data     = 32'hC000_0000 + 32'(pushed);
      bus3.out_allowin = 1'($urandom_range(0, 1));
      settle();
      if (bus3.out_valid && bus3.out_allowin) begin
        if (exp_q.size() == 0) begin
          chk("q3_unexpected_pop", 32'd1, 32'd0);
        end else begin
          head = exp_q.pop_front();
          chk("q3_order", bus3.out_data, head);
          popped++;
        end
      end
      if (bus3.in_valid && bus3.in_allowin) begin
        exp_q.push_back(bus3.in_data);
        pushed++;
      end
      step();
      cyc++;
    end
    bus3.in_valid    = 1'b0;
    bus3.out_allowin = 1'b0;
    chk("q3_all_popped", 32'(popped), 32'd10);
    settle();
    chk("q3_final_count", 32'(bus3.count), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
